// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the USB_CDC IN-stream arbiter: FSM state encoding,
// the tag byte prefix and a ceil_log2 helper for sizing counters/pointers.
// No ports; imported by cdc_in_arbiter and rr_pick.
package cdc_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TAG   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_TAG   = TAG,
    ST_BURST = BURST
  } arb_state_t;

  // Upper nibble of the per-grant tag byte; lower nibble carries the index.
  localparam logic [3:0] TAG_PREFIX = 4'hF;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Latency: zero cycles. Backpressure: none (pure function of req/ptr).
// Ports: req = request vector, ptr = highest-priority index,
//        idx = first set request at or above ptr (mod N_REQ), any = some request set.
module rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = ceil_log2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest set request
  // (lowest offset from ptr) is the last one written and therefore wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      // explicit wrap at N_REQ, which need not be a power of two
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin share of the single USB_CDC IN byte stream among N_REQ sources.
// Latency: 1 cycle grant from IDLE (+1 tag cycle with ARB_TAG_EN), then zero-latency passthrough.
// Backpressure: in_ready_i drives the granted requester's ready directly; output held until consumed.
// Ports: clk_i/rstn_i (async active-low, 2-flop release), req_data_i/req_valid_i/req_ready_o
//        (per-requester byte streams), in_data_o/in_valid_o/in_ready_i (USB_CDC IN), grant_o (one-hot).
// Macro: ARB_TAG_EN -- when defined each grant first emits a tag byte {4'hF, idx}.
module cdc_in_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 64
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_REQ-1:0]   grant_o
);

  localparam int PW = ceil_log2(N_REQ);
  localparam int CW = ceil_log2(MAX_BURST + 1);

  // Reset asserts asynchronously, releases two clocks after rstn_i rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  arb_state_t       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gidx;
  logic [N_REQ-1:0] r_grant;
  logic [CW-1:0]    r_count;

  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [7:0]       w_cur_dat;
  logic             w_cur_vld;
  logic             w_hs;
  logic             w_last;
  logic [PW-1:0]    w_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (r_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Select the granted requester's byte and valid.
  always_comb begin
    w_cur_dat = 8'h00;
    w_cur_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gidx == PW'(k)) begin
        w_cur_dat = req_data_i[8*k +: 8];
        w_cur_vld = req_valid_i[k];
      end
    end
  end

  assign w_hs       = (r_state == ST_BURST) && w_cur_vld && in_ready_i;
  // This handshake is the MAX_BURST-th byte of the grant.
  assign w_last     = (r_count == CW'(MAX_BURST - 1));
  assign w_ptr_next = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);

`ifdef ARB_TAG_EN
  logic [3:0] w_gidx4;
  assign w_gidx4 = 4'(r_gidx);
`endif

  always_comb begin
    in_valid_o  = 1'b0;
    in_data_o   = 8'h00;
    req_ready_o = '0;
    case (r_state)
`ifdef ARB_TAG_EN
      ST_TAG: begin
        in_valid_o = 1'b1;
        in_data_o  = {TAG_PREFIX, w_gidx4};
      end
`endif
      ST_BURST: begin
        in_valid_o  = w_cur_vld;
        in_data_o   = w_cur_dat;
        req_ready_o = r_grant & {N_REQ{in_ready_i}};
      end
      default: ;
    endcase
  end

  assign grant_o = r_grant;

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_gidx  <= w_pick_idx;
            r_grant <= N_REQ'(1) << w_pick_idx;
            r_count <= '0;
`ifdef ARB_TAG_EN
            r_state <= ST_TAG;
`else
            r_state <= ST_BURST;
`endif
          end
        end
`ifdef ARB_TAG_EN
        ST_TAG: begin
          if (in_ready_i) r_state <= ST_BURST;
        end
`endif
        ST_BURST: begin
          // Exit on a full burst or when the requester runs dry; always
          // via IDLE so the next grant is re-arbitrated from the new pointer.
          if ((w_hs && w_last) || (!w_hs && !w_cur_vld)) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
          end else if (w_hs) begin
            r_count <= r_count + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Self-checking bench for cdc_in_arbiter (N_REQ=3, MAX_BURST=4).
// Reference model tracks owner / bytes left / next-priority index per cycle.
module tb_cdc_in_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;
`ifdef ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn_i;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] grant;

  always #5 clk = ~clk;

  cdc_in_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .grant_o     (grant)
  );

  // Per-requester source FIFOs (bench side).
  logic [7:0] mem [N][1024];
  int head [N];
  int tail [N];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model.
  int owner = -1;   // granted requester, -1 when idle
  int left  = 0;    // data bytes still allowed in this grant
  bit tagp  = 1'b0; // tag byte not yet accepted
  int nxt   = 0;    // first index to consider at next arbitration
  int hold  = 2;    // cycles before internal reset releases

  bit rnd_rdy  = 1'b0;
  int push_pct = 0;
  int run_bytes = 0;
  int runs [$];
  logic [N-1:0] gseq [$];
  logic [N-1:0] prev_grant = '0;
  bit wait_prev = 1'b0;
  logic [7:0] wait_dat = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][tail[k]] = b;
    tail[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (head[k] != tail[k]);
      req_data[8*k +: 8] = req_valid[k] ? mem[k][head[k]] : 8'h00;
    end
    in_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic end_grant();
    runs.push_back(run_bytes);
    run_bytes = 0;
    nxt   = (owner + 1) % N;
    owner = -1;
  endtask

  // Advance the model across one rising edge, using the inputs present at it.
  task automatic update();
    if (!rstn_i) begin
      owner = -1; tagp = 1'b0; nxt = 0; hold = 2;
    end else if (hold > 0) begin
      hold--;
    end else if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (owner < 0 && req_valid[(nxt + i) % N]) owner = (nxt + i) % N;
      end
      if (owner >= 0) begin
        left = MB; tagp = TAG_EN; run_bytes = 0;
      end
    end else if (tagp) begin
      if (in_ready) tagp = 1'b0;
    end else if (req_valid[owner] && in_ready) begin
      head[owner]++;
      run_bytes++;
      left--;
      if (left == 0) end_grant();
    end else if (!req_valid[owner]) begin
      end_grant();
    end
  endtask

  task automatic step();
    logic         ev;
    logic [7:0]   ed;
    logic [N-1:0] er;
    logic [N-1:0] eg;
    @(negedge clk);
    ev = 1'b0; ed = 8'h00; er = '0; eg = '0;
    if (owner >= 0) begin
      eg = N'(1) << owner;
      if (tagp) begin
        ev = 1'b1;
        ed = {4'hF, 4'(owner)};
      end else begin
        ev = (head[owner] != tail[owner]);
        ed = ev ? mem[owner][head[owner]] : 8'h00;
        er = in_ready ? eg : '0;
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("in_valid", 32'(in_valid), 32'(ev));
    chk("in_data", 32'(in_data), 32'(ed));
    chk("req_ready", 32'(req_ready), 32'(er));
    if (wait_prev) begin
      chk("hold_valid", 32'(in_valid), 32'd1);
      chk("hold_data", 32'(in_data), 32'(wait_dat));
    end
    wait_prev = ev && !in_ready;
    wait_dat  = ed;
    if (grant != '0 && grant != prev_grant) gseq.push_back(grant);
    prev_grant = grant;
    @(posedge clk);
    #1;
    update();
    if (push_pct > 0) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 99) < push_pct && tail[k] < 1000) push(k, 8'($urandom));
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    owner = -1; tagp = 1'b0; nxt = 0; hold = 2;
    wait_prev = 1'b0; run_bytes = 0;
    #1;
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_in_data", 32'(in_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    repeat (3) step();
    rstn_i = 1'b1;
  endtask

  task automatic chk_drained(input string tag);
    for (int k = 0; k < N; k++) chk(tag, 32'(tail[k] - head[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
    rstn_i = 1'b0;
    drive();
    #2;

    // 1: single requester, 10 bytes -> data runs of 4,4,2 in order
    do_reset();
    runs.delete();
    for (int i = 0; i < 10; i++) push(0, 8'(8'h10 + i));
    drive();
    repeat (30) step();
    chk("t1_runs", 32'(runs.size()), 32'd3);
    chk("t1_run0", 32'(runs[0]), 32'd4);
    chk("t1_run1", 32'(runs[1]), 32'd4);
    chk("t1_run2", 32'(runs[2]), 32'd2);
    chk_drained("t1_drained");

    // 2: two requesters continuously valid -> grants alternate 0,1,0,1
    do_reset();
    runs.delete(); gseq.delete(); prev_grant = '0;
    for (int i = 0; i < 12; i++) begin push(0, 8'(8'h40 + i)); push(1, 8'(8'h80 + i)); end
    drive();
    repeat (40) step();
    chk("t2_g0", 32'(gseq[0]), 32'b001);
    chk("t2_g1", 32'(gseq[1]), 32'b010);
    chk("t2_g2", 32'(gseq[2]), 32'b001);
    chk("t2_g3", 32'(gseq[3]), 32'b010);
    chk("t2_run0", 32'(runs[0]), 32'd4);
    chk("t2_run1", 32'(runs[1]), 32'd4);
    chk_drained("t2_drained");

    // 3: req1 runs dry after 2 bytes; pointer moves past it, req0 wins next
    gseq.delete(); prev_grant = '0;
    push(1, 8'hC1); push(1, 8'hC2);
    drive();
    repeat (2) step();
    push(0, 8'hD0); push(0, 8'hD1);
    drive();
    repeat (15) step();
    chk("t3_g0", 32'(gseq[0]), 32'b010);
    chk("t3_g1", 32'(gseq[1]), 32'b001);
    chk_drained("t3_drained");

    // 4: random traffic with random in_ready
    rnd_rdy = 1'b1; push_pct = 30;
    repeat (600) step();
    push_pct = 0; rnd_rdy = 1'b0;
    repeat (300) step();
    chk_drained("t4_drained");

    // 5: reset mid-burst, then first valid requester from index 0 wins
    for (int i = 0; i < 8; i++) push(2, 8'(8'hE0 + i));
    push(1, 8'h5A); push(1, 8'h5B); push(1, 8'h5C);
    drive();
    for (int i = 0; i < 12 && !(owner >= 0 && !tagp && run_bytes > 0); i++) step();
    do_reset();
    gseq.delete(); prev_grant = '0;
    repeat (40) step();
    chk("t5_first", 32'(gseq[0]), 32'b010);
    chk_drained("t5_drained");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
